// File: rtl/ufm_access_arbiter.sv
// ---------------------------------------------------------------------------
// ufm_access_arbiter
//
// Purpose:
//   Shares the single UFM command interface and DPRAM port B of the EFB/UFM
//   wishbone controller between two requesters.
//   - Requester 0 is the event-save writer.
//   - Requester 1 is the erase/readback client.
//   A requester holds req high to own the interface (lock-style grant). While
//   it owns the interface it has exclusive DPRAM access. It may issue any
//   number of UFM commands. Each command is sequenced as GO -> BUSY high ->
//   BUSY low, and ends with a done pulse, plus an err pulse when it failed.
//
// Optional feature (macro UFM_ARB_WDT_EN):
//   When defined, two watchdogs are active:
//   - GO is dropped after ACK_CYC cycles without BUSY rising.
//   - RUN is abandoned after TIMEOUT_CYC cycles of BUSY high.
//   Both end the command with an error. When undefined there are no
//   watchdog counters, and errors come only from err_i.
//
// Ports:
//   clk_i, resetn_i           clock, asynchronous active-low reset
//   req*_i                    level request / hold ownership
//   start*_i                  one-cycle command strobe (owner, OWNED only)
//   cmd*_i, page*_i           UFM command and page per requester
//   mem*_we_i/ce_i/addr_i/wr_data_i  per-requester DPRAM port B strobes
//   gnt*_o                    ownership grant
//   done*_o, err*_o           one-cycle completion / error pulses
//   cmd_o, ufm_page_o, go_o   UFM controller command interface
//   busy_i, err_i             UFM controller status
//   mem_we_o/ce_o/addr_o/wr_data_o   muxed DPRAM port B
//   mem_rd_data_i/o           DPRAM read data, broadcast to both requesters
// ---------------------------------------------------------------------------
module ufm_access_arbiter
`ifdef UFM_ARB_WDT_EN
#(
  parameter logic [23:0] TIMEOUT_CYC = 24'd2400000,
  parameter logic [7:0]  ACK_CYC     = 8'd16
)
`endif
(
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic        start0_i,
  input  logic        start1_i,
  input  logic [2:0]  cmd0_i,
  input  logic [2:0]  cmd1_i,
  input  logic [10:0] page0_i,
  input  logic [10:0] page1_i,
  input  logic        mem0_we_i,
  input  logic        mem0_ce_i,
  input  logic        mem1_we_i,
  input  logic        mem1_ce_i,
  input  logic [3:0]  mem0_addr_i,
  input  logic [3:0]  mem1_addr_i,
  input  logic [7:0]  mem0_wr_data_i,
  input  logic [7:0]  mem1_wr_data_i,
  output logic        gnt0_o,
  output logic        gnt1_o,
  output logic        done0_o,
  output logic        done1_o,
  output logic        err0_o,
  output logic        err1_o,
  output logic [2:0]  cmd_o,
  output logic [10:0] ufm_page_o,
  output logic        go_o,
  input  logic        busy_i,
  input  logic        err_i,
  output logic        mem_we_o,
  output logic        mem_ce_o,
  output logic [3:0]  mem_addr_o,
  output logic [7:0]  mem_wr_data_o,
  input  logic [7:0]  mem_rd_data_i,
  output logic [7:0]  mem_rd_data_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_OWNED = 3'd1,
    ST_ISSUE = 3'd2,
    ST_RUN   = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  // owner_r doubles as the round-robin last-grant pointer: the last grant
  // is always the current (or most recent) owner.
  logic        owner_r;
  logic        next_owner_s;
  logic        fin_err_s;
  logic        latch_cmd_s;
  logic        own_req_s;
  logic        own_start_s;
  logic [2:0]  own_cmd_s;
  logic [10:0] own_page_s;

  logic        gnt0_r;
  logic        gnt1_r;
  logic        done0_r;
  logic        done1_r;
  logic        err0_r;
  logic        err1_r;
  logic        go_r;
  logic [2:0]  cmd_r;
  logic [10:0] page_r;

  assign own_req_s   = owner_r ? req1_i   : req0_i;
  assign own_start_s = owner_r ? start1_i : start0_i;
  assign own_cmd_s   = owner_r ? cmd1_i   : cmd0_i;
  assign own_page_s  = owner_r ? page1_i  : page0_i;

`ifdef UFM_ARB_WDT_EN
  logic [23:0] wdt_cnt_r;
  logic        wdt_clr_s;
  logic        ack_hit_s;
  logic        tmo_hit_s;

  // The counter restarts on each entry to ISSUE or RUN, so the limit check
  // against (limit - 1) gives exactly `limit` cycles in that state.
  assign wdt_clr_s = ((next_state_s == ST_ISSUE) && (state_r != ST_ISSUE)) ||
                     ((next_state_s == ST_RUN)   && (state_r != ST_RUN));
  assign ack_hit_s = (wdt_cnt_r >= ({16'd0, ACK_CYC} - 24'd1));
  assign tmo_hit_s = (wdt_cnt_r >= (TIMEOUT_CYC - 24'd1));

  // Saturating watchdog cycle counter shared by ISSUE and RUN
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      wdt_cnt_r <= 24'd0;
    end else if (wdt_clr_s) begin
      wdt_cnt_r <= 24'd0;
    end else if (wdt_cnt_r != 24'hFF_FFFF) begin
      wdt_cnt_r <= wdt_cnt_r + 24'd1;
    end else begin
      wdt_cnt_r <= wdt_cnt_r;
    end
  end
`endif

  // Next-state, ownership and command-latch decisions
  always_comb begin
    next_state_s = state_r;
    next_owner_s = owner_r;
    fin_err_s    = 1'b0;
    latch_cmd_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req0_i && req1_i) begin
          // Contention: the requester that was not granted last wins.
          next_owner_s = ~owner_r;
          next_state_s = ST_OWNED;
        end else if (req0_i) begin
          next_owner_s = 1'b0;
          next_state_s = ST_OWNED;
        end else if (req1_i) begin
          next_owner_s = 1'b1;
          next_state_s = ST_OWNED;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_OWNED: begin
        // Release has priority: a start coinciding with req low is dropped.
        if (!own_req_s) begin
          next_state_s = ST_IDLE;
        end else if (own_start_s) begin
          next_state_s = ST_ISSUE;
          latch_cmd_s  = 1'b1;
        end else begin
          next_state_s = ST_OWNED;
        end
      end
      ST_ISSUE: begin
        if (busy_i) begin
          next_state_s = ST_RUN;
`ifdef UFM_ARB_WDT_EN
        end else if (ack_hit_s) begin
          next_state_s = ST_FIN;
          fin_err_s    = 1'b1;
`endif
        end else begin
          next_state_s = ST_ISSUE;
        end
      end
      ST_RUN: begin
        if (!busy_i) begin
          next_state_s = ST_FIN;
          fin_err_s    = err_i;
`ifdef UFM_ARB_WDT_EN
        end else if (tmo_hit_s) begin
          next_state_s = ST_FIN;
          fin_err_s    = 1'b1;
`endif
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_FIN: begin
        next_state_s = ST_OWNED;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State and ownership registers
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_r <= ST_IDLE;
      owner_r <= 1'b1;
    end else begin
      state_r <= next_state_s;
      owner_r <= next_owner_s;
    end
  end

  // Registered grant, GO and completion pulses derived from the next state
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      gnt0_r  <= 1'b0;
      gnt1_r  <= 1'b0;
      go_r    <= 1'b0;
      done0_r <= 1'b0;
      done1_r <= 1'b0;
      err0_r  <= 1'b0;
      err1_r  <= 1'b0;
    end else begin
      gnt0_r  <= (next_state_s != ST_IDLE) && !next_owner_s;
      gnt1_r  <= (next_state_s != ST_IDLE) &&  next_owner_s;
      go_r    <= (next_state_s == ST_ISSUE);
      done0_r <= (next_state_s == ST_FIN) && !next_owner_s;
      done1_r <= (next_state_s == ST_FIN) &&  next_owner_s;
      err0_r  <= (next_state_s == ST_FIN) && fin_err_s && !next_owner_s;
      err1_r  <= (next_state_s == ST_FIN) && fin_err_s &&  next_owner_s;
    end
  end

  // Command/page capture on an accepted start; held until the next one
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      cmd_r  <= 3'd0;
      page_r <= 11'd0;
    end else if (latch_cmd_s) begin
      cmd_r  <= own_cmd_s;
      page_r <= own_page_s;
    end else begin
      cmd_r  <= cmd_r;
      page_r <= page_r;
    end
  end

  // DPRAM port B mux: address/data follow the owner, strobes only in OWNED
  always_comb begin
    mem_we_o      = 1'b0;
    mem_ce_o      = 1'b0;
    mem_addr_o    = 4'd0;
    mem_wr_data_o = 8'd0;
    if (state_r != ST_IDLE) begin
      mem_addr_o    = owner_r ? mem1_addr_i    : mem0_addr_i;
      mem_wr_data_o = owner_r ? mem1_wr_data_i : mem0_wr_data_i;
    end else begin
      mem_addr_o    = 4'd0;
      mem_wr_data_o = 8'd0;
    end
    if (state_r == ST_OWNED) begin
      mem_we_o = owner_r ? mem1_we_i : mem0_we_i;
      mem_ce_o = owner_r ? mem1_ce_i : mem0_ce_i;
    end else begin
      mem_we_o = 1'b0;
      mem_ce_o = 1'b0;
    end
  end

  assign mem_rd_data_o = mem_rd_data_i;
  assign gnt0_o        = gnt0_r;
  assign gnt1_o        = gnt1_r;
  assign go_o          = go_r;
  assign done0_o       = done0_r;
  assign done1_o       = done1_r;
  assign err0_o        = err0_r;
  assign err1_o        = err1_r;
  assign cmd_o         = cmd_r;
  assign ufm_page_o    = page_r;

endmodule

// File: tb/tb_ufm_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ufm_access_arbiter
//
// Bench for ufm_access_arbiter. A behavioural model tracks the owner, the
// command phase and the latched command. A compare process checks every DUT
// output against the model on each falling edge. Directed sequences pin
// literal expectations, and a randomized phase follows them. A small UFM
// responder drives busy_i/err_i in reaction to go_o.
// ---------------------------------------------------------------------------
module tb_ufm_access_arbiter;

`ifdef UFM_ARB_WDT_EN
  localparam int ACK_LIM = 16;
  localparam int TMO_LIM = 2400000;
`endif

  logic        clk_i = 1'b0;
  logic        resetn_i = 1'b0;
  logic        req0_i = 1'b0, req1_i = 1'b0, start0_i = 1'b0, start1_i = 1'b0;
  logic [2:0]  cmd0_i = 3'd0, cmd1_i = 3'd0;
  logic [10:0] page0_i = 11'd0, page1_i = 11'd0;
  logic        mem0_we_i = 1'b0, mem0_ce_i = 1'b0, mem1_we_i = 1'b0, mem1_ce_i = 1'b0;
  logic [3:0]  mem0_addr_i = 4'd0, mem1_addr_i = 4'd0;
  logic [7:0]  mem0_wr_data_i = 8'd0, mem1_wr_data_i = 8'd0;
  logic        gnt0_o, gnt1_o, done0_o, done1_o, err0_o, err1_o, go_o;
  logic [2:0]  cmd_o;
  logic [10:0] ufm_page_o;
  logic        busy_i = 1'b0, err_i = 1'b0;
  logic        mem_we_o, mem_ce_o;
  logic [3:0]  mem_addr_o;
  logic [7:0]  mem_wr_data_o;
  logic [7:0]  mem_rd_data_i = 8'd0;
  logic [7:0]  mem_rd_data_o;

  int n_vec = 0;
  int n_mis = 0;
  bit chk_en = 1'b0;

  ufm_access_arbiter dut (
    .clk_i(clk_i), .resetn_i(resetn_i),
    .req0_i(req0_i), .req1_i(req1_i), .start0_i(start0_i), .start1_i(start1_i),
    .cmd0_i(cmd0_i), .cmd1_i(cmd1_i), .page0_i(page0_i), .page1_i(page1_i),
    .mem0_we_i(mem0_we_i), .mem0_ce_i(mem0_ce_i), .mem1_we_i(mem1_we_i), .mem1_ce_i(mem1_ce_i),
    .mem0_addr_i(mem0_addr_i), .mem1_addr_i(mem1_addr_i),
    .mem0_wr_data_i(mem0_wr_data_i), .mem1_wr_data_i(mem1_wr_data_i),
    .gnt0_o(gnt0_o), .gnt1_o(gnt1_o), .done0_o(done0_o), .done1_o(done1_o),
    .err0_o(err0_o), .err1_o(err1_o), .cmd_o(cmd_o), .ufm_page_o(ufm_page_o),
    .go_o(go_o), .busy_i(busy_i), .err_i(err_i),
    .mem_we_o(mem_we_o), .mem_ce_o(mem_ce_o), .mem_addr_o(mem_addr_o),
    .mem_wr_data_o(mem_wr_data_o), .mem_rd_data_i(mem_rd_data_i), .mem_rd_data_o(mem_rd_data_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, vectors=%0d", n_vec);
    $fatal(1, "global timeout");
  end

  // ---------------- behavioural model ----------------
  // owner = -1 when nobody holds the interface. A command is either waiting
  // for BUSY (m_go), running (m_run) or reporting (m_fin).
  int          m_owner = -1;
  int          m_last  = 1;
  bit          m_go = 1'b0, m_run = 1'b0, m_fin = 1'b0, m_ferr = 1'b0;
  int          m_wait = 0;
  logic [2:0]  m_cmd = 3'd0;
  logic [10:0] m_page = 11'd0;

  always @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      m_owner = -1; m_last = 1; m_go = 1'b0; m_run = 1'b0; m_fin = 1'b0;
      m_ferr = 1'b0; m_wait = 0; m_cmd = 3'd0; m_page = 11'd0;
    end else begin
      bit rq[2];
      bit st[2];
      rq[0] = req0_i; rq[1] = req1_i; st[0] = start0_i; st[1] = start1_i;
      if (m_owner < 0) begin
        if (rq[0] && rq[1]) m_owner = 1 - m_last;
        else if (rq[0]) m_owner = 0;
        else if (rq[1]) m_owner = 1;
        if (m_owner >= 0) m_last = m_owner;
      end else if (m_fin) begin
        m_fin = 1'b0; m_ferr = 1'b0;
      end else if (m_go) begin
        if (busy_i) begin
          m_go = 1'b0; m_run = 1'b1; m_wait = 0;
        end else begin
          m_wait++;
`ifdef UFM_ARB_WDT_EN
          if (m_wait >= ACK_LIM) begin m_go = 1'b0; m_fin = 1'b1; m_ferr = 1'b1; end
`endif
        end
      end else if (m_run) begin
        if (!busy_i) begin
          m_run = 1'b0; m_fin = 1'b1; m_ferr = err_i;
        end else begin
          m_wait++;
`ifdef UFM_ARB_WDT_EN
          if (m_wait >= TMO_LIM) begin m_run = 1'b0; m_fin = 1'b1; m_ferr = 1'b1; end
`endif
        end
      end else begin
        if (!rq[m_owner]) begin
          m_owner = -1;
        end else if (st[m_owner]) begin
          m_go = 1'b1; m_wait = 0;
          m_cmd  = (m_owner == 1) ? cmd1_i : cmd0_i;
          m_page = (m_owner == 1) ? page1_i : page0_i;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk_i) begin
    if (chk_en) begin
      logic [42:0] e, a;
      bit owned_quiet;
      logic e_we, e_ce;
      logic [3:0] e_addr;
      logic [7:0] e_wd;
      owned_quiet = (m_owner >= 0) && !m_go && !m_run && !m_fin;
      e_we = 1'b0; e_ce = 1'b0; e_addr = 4'd0; e_wd = 8'd0;
      if (m_owner == 0) begin e_addr = mem0_addr_i; e_wd = mem0_wr_data_i; end
      if (m_owner == 1) begin e_addr = mem1_addr_i; e_wd = mem1_wr_data_i; end
      if (owned_quiet) begin
        e_we = (m_owner == 1) ? mem1_we_i : mem0_we_i;
        e_ce = (m_owner == 1) ? mem1_ce_i : mem0_ce_i;
      end
      e = {m_owner == 1, m_owner == 0, m_go, m_fin && m_owner == 1, m_fin && m_owner == 0,
           m_fin && m_ferr && m_owner == 1, m_fin && m_ferr && m_owner == 0,
           m_cmd, m_page, e_we, e_ce, e_addr, e_wd, mem_rd_data_i};
      a = {gnt1_o, gnt0_o, go_o, done1_o, done0_o, err1_o, err0_o, cmd_o, ufm_page_o,
           mem_we_o, mem_ce_o, mem_addr_o, mem_wr_data_o, mem_rd_data_o};
      n_vec++;
      if (a !== e) begin
        n_mis++;
        $display("FAIL model_cmp @%0t: dut=%h model=%h", $time, a, e);
      end
    end
  end

  // ---------------- UFM responder ----------------
  int gcnt = 0, bcnt = 0, resp_delay = 0, resp_len = 0;
  bit resp_err = 1'b0, resp_en = 1'b0, resp_rand = 1'b0;

  task automatic pick_resp();
`ifdef UFM_ARB_WDT_EN
    resp_delay = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 3));
`else
    resp_delay = $urandom_range(0, 3);
`endif
    resp_len = $urandom_range(0, 12);
    resp_err = ($urandom_range(0, 3) == 0);
  endtask

  always @(negedge clk_i) begin
    #1;
    if (!resp_en) begin
      busy_i = 1'b0; err_i = 1'b0; gcnt = 0; bcnt = 0;
    end else if (!busy_i) begin
      err_i = 1'b0;
      if (go_o) begin
        if (gcnt >= resp_delay) begin busy_i = 1'b1; bcnt = 0; gcnt = 0; end
        else gcnt++;
      end else begin
        gcnt = 0;
      end
    end else begin
      if (bcnt >= resp_len) begin
        busy_i = 1'b0; err_i = resp_err;
        if (resp_rand) pick_resp();
      end else begin
        bcnt++;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk_i);
    #2;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_busy(input logic lvl, input string nm);
    int n = 0;
    while (busy_i !== lvl && n < 300) begin
      tick();
      n++;
    end
    chk(nm, busy_i, lvl);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    repeat (2) tick();
    resetn_i = 1'b1;
    chk_en = 1'b1;
    chk("rst_gnt0", gnt0_o, 0); chk("rst_gnt1", gnt1_o, 0);
    chk("rst_go", go_o, 0);     chk("rst_done0", done0_o, 0);
    chk("rst_err0", err0_o, 0); chk("rst_cmd", cmd_o, 0);
    chk("rst_page", ufm_page_o, 0); chk("rst_memwe", mem_we_o, 0);

    // 1: single requester, one good command with a 50-cycle BUSY
    req0_i = 1'b1;
    tick();
    chk("t1_gnt0", gnt0_o, 1);
    resp_en = 1'b1; resp_delay = 0; resp_len = 49; resp_err = 1'b0;
    start0_i = 1'b1; cmd0_i = 3'b010; page0_i = 11'h005;
    tick();
    start0_i = 1'b0;
    chk("t1_go", go_o, 1); chk("t1_cmd", cmd_o, 3'd2); chk("t1_page", ufm_page_o, 11'h005);
    wait_busy(1'b1, "t1_busy_hi");
    wait_busy(1'b0, "t1_busy_lo");
    chk("t1_done_early", done0_o, 0);
    tick();
    chk("t1_done", done0_o, 1); chk("t1_err", err0_o, 0);
    tick();
    chk("t1_done_clr", done0_o, 0); chk("t1_gnt_kept", gnt0_o, 1);
    chk("t1_cmd_hold", cmd_o, 3'd2);
    req0_i = 1'b0;
    repeat (2) tick();

    // 2: contention and round robin from a fresh reset
    resetn_i = 1'b0; tick(); resetn_i = 1'b1;
    req0_i = 1'b1; req1_i = 1'b1;
    tick();
    chk("t2_first_gnt0", gnt0_o, 1); chk("t2_first_gnt1", gnt1_o, 0);
    req0_i = 1'b0; req1_i = 1'b0;
    tick();
    chk("t2_rel", gnt0_o, 0);
    req0_i = 1'b1; req1_i = 1'b1;
    tick();
    chk("t2_rr_gnt1", gnt1_o, 1); chk("t2_rr_gnt0", gnt0_o, 0);
    req1_i = 1'b0;
    tick(); tick();
    chk("t2_hand_gnt0", gnt0_o, 1);
    req1_i = 1'b1; req0_i = 1'b0;
    tick(); tick();
    chk("t2_hand_gnt1", gnt1_o, 1);

    // 3: owner 1 drives DPRAM, owner 0 toggles and must not leak through
    mem1_addr_i = 4'h3; mem1_we_i = 1'b1; mem1_ce_i = 1'b1; mem1_wr_data_i = 8'hA5;
    for (int i = 0; i < 6; i++) begin
      mem0_we_i = $urandom_range(0, 1); mem0_ce_i = $urandom_range(0, 1);
      mem0_addr_i = $urandom_range(0, 15); mem0_wr_data_i = $urandom_range(0, 255);
      tick();
      chk("t3_addr", mem_addr_o, 4'h3); chk("t3_data", mem_wr_data_o, 8'hA5);
      chk("t3_we", mem_we_o, 1);
    end
    req1_i = 1'b0;
    tick();
    chk("t3_rel_we", mem_we_o, 0); chk("t3_rel_ce", mem_ce_o, 0);
    mem1_we_i = 1'b0; mem1_ce_i = 1'b0;
    tick();

    // 4: err_i at BUSY fall on requester 1, then another accepted start
    req1_i = 1'b1;
    tick();
    resp_delay = 1; resp_len = 5; resp_err = 1'b1;
    start1_i = 1'b1; cmd1_i = 3'b101; page1_i = 11'h2A3;
    tick();
    start1_i = 1'b0;
    wait_busy(1'b1, "t4_busy_hi");
    wait_busy(1'b0, "t4_busy_lo");
    tick();
    chk("t4_done1", done1_o, 1); chk("t4_err1", err1_o, 1); chk("t4_gnt1", gnt1_o, 1);
    tick();
    chk("t4_err1_clr", err1_o, 0);
    resp_err = 1'b0;
    start1_i = 1'b1; cmd1_i = 3'b001;
    tick();
    start1_i = 1'b0;
    chk("t4_go2", go_o, 1); chk("t4_cmd2", cmd_o, 3'd1);
    wait_busy(1'b1, "t4_busy2_hi");
    wait_busy(1'b0, "t4_busy2_lo");
    tick();
    chk("t4_done2", done1_o, 1); chk("t4_err2", err1_o, 0);
    req1_i = 1'b0;
    repeat (3) tick();

`ifdef UFM_ARB_WDT_EN
    // 5: BUSY never rises, GO watchdog ends the command with an error
    resp_en = 1'b0;
    req0_i = 1'b1;
    tick();
    start0_i = 1'b1;
    tick();
    start0_i = 1'b0;
    n = 0;
    while (go_o === 1'b1 && n < 40) begin n++; tick(); end
    chk("t5_go_cycles", n, 16);
    chk("t5_done0", done0_o, 1); chk("t5_err0", err0_o, 1); chk("t5_gnt0", gnt0_o, 1);
    req0_i = 1'b0;
    repeat (3) tick();
    resp_en = 1'b1;
`endif

    // 6: asynchronous reset in the middle of RUN
    resp_delay = 0; resp_len = 30; resp_err = 1'b0;
    req0_i = 1'b1;
    tick();
    start0_i = 1'b1;
    tick();
    start0_i = 1'b0;
    wait_busy(1'b1, "t6_busy_hi");
    repeat (3) tick();
    resetn_i = 1'b0; resp_en = 1'b0;
    #1;
    chk("t6_go", go_o, 0); chk("t6_gnt0", gnt0_o, 0);
    chk("t6_done0", done0_o, 0); chk("t6_err0", err0_o, 0);
    tick();
    resetn_i = 1'b1; resp_en = 1'b1;
    tick();
    chk("t6_regnt0", gnt0_o, 1);
    req0_i = 1'b0;
    repeat (2) tick();

    // 7: randomized traffic checked by the model every cycle
    resp_rand = 1'b1;
    pick_resp();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) req0_i = ~req0_i;
      if ($urandom_range(0, 15) == 0) req1_i = ~req1_i;
      start0_i = ($urandom_range(0, 5) == 0);
      start1_i = ($urandom_range(0, 5) == 0);
      cmd0_i = $urandom_range(0, 7); cmd1_i = $urandom_range(0, 7);
      page0_i = $urandom_range(0, 2047); page1_i = $urandom_range(0, 2047);
      mem0_we_i = $urandom_range(0, 1); mem0_ce_i = $urandom_range(0, 1);
      mem1_we_i = $urandom_range(0, 1); mem1_ce_i = $urandom_range(0, 1);
      mem0_addr_i = $urandom_range(0, 15); mem1_addr_i = $urandom_range(0, 15);
      mem0_wr_data_i = $urandom_range(0, 255); mem1_wr_data_i = $urandom_range(0, 255);
      mem_rd_data_i = $urandom_range(0, 255);
      tick();
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
